// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the DataMemory initiator path: access-size encodings,
// the controller state type and the alignment rule applied to every request.
// -----------------------------------------------------------------------------
package mem_pkg;

  // Access-size encodings as seen on req_size and DataMemory.Size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } mau_state_t;

  // True when a request of this size may legally start at this address.
  // Only the two low address bits matter; size 11 is never legal.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load formatter. DataMemory returns bytes and halfwords
// right-justified in DO; this widens them to DATA_W by sign or zero fill.
//   data_i   in  DATA_W  raw DO from DataMemory
//   size_i   in  2       access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   signed_i in  1       1 = replicate the top bit of the item, 0 = zero fill
//   rdata_o  out DATA_W  extended load result
// -----------------------------------------------------------------------------
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] rdata_o
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for sizes the case does not list.
    rdata_o = data_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{(DATA_W-8){signed_i & data_i[7]}},  data_i[7:0]};
      SZ_HALF: rdata_o = {{(DATA_W-16){signed_i & data_i[15]}}, data_i[15:0]};
      default: rdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator-side controller for DataMemory. Takes one load/store request at a
// time, rejects misaligned or illegal-size requests without touching memory,
// performs a single access cycle, and returns the (extended) load data.
//   clk, reset               clock; asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata   request fields
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       response payload
//   mem_A/DI/Size/RW/E       DataMemory drive; mem_DO is its read data
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_DI,
  input  logic [DATA_W-1:0] mem_DO,
  output logic [1:0]        mem_Size,
  output logic              mem_RW,
  output logic              mem_E
);

  mau_state_t        state_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [DATA_W-1:0] mem_di_q;
  logic [1:0]        mem_size_q;
  logic              mem_rw_q;
  logic              mem_e_q;
  logic              we_q;
  logic              signed_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              req_legal;
  logic [DATA_W-1:0] load_data;

  assign req_legal = is_aligned(req_size, req_addr[1:0]);

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .data_i   (mem_DO),
    .size_i   (mem_size_q),
    .signed_i (signed_q),
    .rdata_o  (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_a_q     <= '0;
      mem_di_q    <= '0;
      mem_size_q  <= SZ_BYTE;
      mem_rw_q    <= 1'b0;
      mem_e_q     <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_legal) begin
              // The memory-side registers are the request register: they
              // present the access during ACCESS and then simply hold.
              mem_a_q    <= req_addr;
              mem_di_q   <= req_wdata;
              mem_size_q <= req_size;
              mem_rw_q   <= req_we;
              mem_e_q    <= req_we;
              we_q       <= req_we;
              signed_q   <= req_signed;
              state_q    <= ACCESS;
            end else begin
              // Rejected request: answer at once, memory is never enabled.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end
          end
        end
        ACCESS: begin
          // Loads run with E low; DO is valid combinationally and is captured
          // at the edge that closes the access.
          mem_e_q     <= 1'b0;
          mem_rw_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? '0 : load_data;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_A     = mem_a_q;
  assign mem_DI    = mem_di_q;
  assign mem_Size  = mem_size_q;
  assign mem_RW    = mem_rw_q;
  assign mem_E     = mem_e_q;

endmodule
